// File: rtl/layered_sprite_compositor.sv
// Layered sprite compositor: NUM_LAYERS sprites over a fixed background.
// Stage 1 hit-tests each layer against frame-shadowed attributes and issues
// sprite-ROM addresses, stage 2 priority-resolves the returned indices,
// stage 3 looks the winner up in a runtime-writable palette.
// Fixed 3-cycle latency, one pixel per clock, no stalls.

// Per-layer stage 1: hit test and sprite-ROM address generation.
module lsc_layer_stage1 #(
  parameter int SPR_W     = 20,
  parameter int SPR_H     = 20,
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           draw_x,
  input  logic [9:0]           draw_y,
  input  logic [9:0]           sx,
  input  logic [9:0]           sy,
  input  logic                 en,
  input  logic                 flip,
  input  logic                 blink,
  input  logic                 blink_phase,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 hit
);
  logic [10:0]          dx, dy, lx;
  logic                 hit_c;
  logic [ADDR_BITS-1:0] addr_c;

  // 11-bit unsigned offsets; the >= compares keep negative offsets from hitting
  assign dx    = {1'b0, draw_x} - {1'b0, sx};
  assign dy    = {1'b0, draw_y} - {1'b0, sy};
  // a sprite whose left edge lies off-screen can never be visible
  assign hit_c = en & (sx < 10'd640) &
                 (draw_x >= sx) & (dx < 11'(SPR_W)) &
                 (draw_y >= sy) & (dy < 11'(SPR_H)) &
                 ~(blink & ~blink_phase);
  assign lx     = flip ? (11'(SPR_W - 1) - dx) : dx;
  assign addr_c = ADDR_BITS'(lx) + ADDR_BITS'(dy) * ADDR_BITS'(SPR_W);

  // register hit and address; the address idles at 0 when the layer misses
  always_ff @(posedge clk) begin
    if (reset) begin
      hit      <= 1'b0;
      rom_addr <= '0;
    end else begin
      hit      <= hit_c;
      rom_addr <= hit_c ? addr_c : '0;
    end
  end
endmodule

module layered_sprite_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          SPR_W        = 20,
  parameter int          SPR_H        = 20,
  parameter int          IDX_BITS     = 4,
  parameter int          ADDR_BITS    = 9,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] BG_COLOR     = 24'h0099ff,
  localparam int         LB           = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic                            pix_valid,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic [NUM_LAYERS*10-1:0]        spr_x,
  input  logic [NUM_LAYERS*10-1:0]        spr_y,
  input  logic [NUM_LAYERS-1:0]           spr_en,
  input  logic [NUM_LAYERS-1:0]           spr_flip,
  input  logic [NUM_LAYERS-1:0]           spr_blink,
  output logic [NUM_LAYERS*ADDR_BITS-1:0] rom_addr,
  input  logic [NUM_LAYERS*IDX_BITS-1:0]  rom_data,
  input  logic                            pal_we,
  input  logic [LB+IDX_BITS-1:0]          pal_addr,
  input  logic [23:0]                     pal_wdata,
  output logic [7:0]                      Red,
  output logic [7:0]                      Green,
  output logic [7:0]                      Blue,
  output logic                            pix_valid_out,
  output logic                            blink_phase
);
  localparam int STAGES = 3;
  localparam int CW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PAL_N  = 1 << (LB + IDX_BITS);

  typedef struct packed {
    logic                bg;
    logic [LB-1:0]       layer;
    logic [IDX_BITS-1:0] idx;
  } s2_t;

  logic [NUM_LAYERS-1:0][9:0]           sh_x, sh_y;
  logic [NUM_LAYERS-1:0]                sh_en, sh_flip, sh_blink;
  logic [CW-1:0]                        frame_cnt;
  logic [STAGES-1:0]                    vld_pipe;
  logic [NUM_LAYERS-1:0][ADDR_BITS-1:0] addr_q;
  logic [NUM_LAYERS-1:0]                hit1;
  logic [NUM_LAYERS-1:0][IDX_BITS-1:0]  idx_in;
  s2_t                                  s2_d, s2_q;
  logic [23:0]                          pal [PAL_N];
  logic [23:0]                          rgb_q;

  assign rom_addr      = addr_q;
  assign idx_in        = rom_data;
  assign pix_valid_out = vld_pipe[STAGES-1];
  assign Red           = rgb_q[23:16];
  assign Green         = rgb_q[15:8];
  assign Blue          = rgb_q[7:0];

  // attributes latch only at frame start so a frame never tears
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_en    <= '0;
      sh_flip  <= '0;
      sh_blink <= '0;
    end else if (frame_start) begin
      sh_x     <= spr_x;
      sh_y     <= spr_y;
      sh_en    <= spr_en;
      sh_flip  <= spr_flip;
      sh_blink <= spr_blink;
    end
  end

  // frame counter; blink phase flips each time it wraps
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

  // pixel-valid travels alongside the data through all three stages
  always_ff @(posedge Clk) begin
    if (Reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-2:0], pix_valid};
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LAYERS; g++) begin : g_layer
      lsc_layer_stage1 #(
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .ADDR_BITS (ADDR_BITS)
      ) u_s1 (
        .clk         (Clk),
        .reset       (Reset),
        .draw_x      (DrawX),
        .draw_y      (DrawY),
        .sx          (sh_x[g]),
        .sy          (sh_y[g]),
        .en          (sh_en[g]),
        .flip        (sh_flip[g]),
        .blink       (sh_blink[g]),
        .blink_phase (blink_phase),
        .rom_addr    (addr_q[g]),
        .hit         (hit1[g])
      );
    end
  endgenerate

  // priority encode: scanning high to low lets the lowest opaque layer win
  always_comb begin
    s2_d.bg    = 1'b1;
    s2_d.layer = '0;
    s2_d.idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit1[i] && (idx_in[i] != '0)) begin
        s2_d.bg    = 1'b0;
        s2_d.layer = LB'(i);
        s2_d.idx   = idx_in[i];
      end
    end
  end

  // stage 2 register: winning {layer, index} or background
  always_ff @(posedge Clk) begin
    if (Reset) s2_q <= '0;
    else       s2_q <= s2_d;
  end

  // palette; a same-cycle read of the written entry still sees the old value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  // stage 3: palette lookup, background fill, blank outside the visible area
  always_ff @(posedge Clk) begin
    if (Reset)             rgb_q <= '0;
    else if (!vld_pipe[1]) rgb_q <= '0;
    else if (s2_q.bg)      rgb_q <= BG_COLOR;
    else                   rgb_q <= pal[{s2_q.layer, s2_q.idx}];
  end
endmodule
